// File: rtl/wb_counter_bank_pkg.sv
// Shared register map, bit positions and helpers for the Wishbone counter bank.
package wb_counter_bank_pkg;

  // Per-channel register word offsets (byte address bits [3:2])
  localparam logic [1:0] REG_CTRL    = 2'd0;
  localparam logic [1:0] REG_COUNT   = 2'd1;
  localparam logic [1:0] REG_COMPARE = 2'd2;
  localparam logic [1:0] REG_STATUS  = 2'd3;

  // CTRL bit positions
  localparam int CTRL_EN      = 0;
  localparam int CTRL_DOWN    = 1;
  localparam int CTRL_ONESHOT = 2;
  localparam int CTRL_IRQEN   = 3;

  // STATUS bit positions
  localparam int STATUS_MATCH = 0;

  // Expand the four Wishbone byte strobes into a 32-bit bit mask
  function automatic logic [31:0] byte_mask(input logic [3:0] sel);
    logic [31:0] mask;
    for (int b = 0; b < 4; b++) begin
      mask[8*b +: 8] = {8{sel[b]}};
    end
    return mask;
  endfunction

endpackage

// File: rtl/wb_counter_bank_channel.sv
// One timer/counter channel: CTRL, COUNT, COMPARE and the sticky match flag.
module counter_channel
  import wb_counter_bank_pkg::*;
#(
  parameter int BITS = 32
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            wr_ctrl,
  input  logic            wr_count,
  input  logic            wr_compare,
  input  logic            wr_status,
  input  logic [3:0]      sel,
  input  logic [31:0]     wdata,
  input  logic [1:0]      reg_sel,
  input  logic            la_load,
  input  logic [BITS-1:0] la_value,
  output logic [BITS-1:0] count,
  output logic [31:0]     rdata,
  output logic            match,
  output logic            irq_req
);

  logic [3:0]      ctrl;
  logic [BITS-1:0] compare;
  logic [31:0]     mask_full;
  logic [BITS-1:0] bit_mask;
  logic [BITS-1:0] wdata_b;
  logic [BITS-1:0] count_merged;
  logic [BITS-1:0] compare_merged;
  logic [BITS-1:0] step_val;
  logic            en;
  logic            down;
  logic            oneshot;
  logic            at_end;
  logic            terminal;
  logic            clear_match;

  assign en      = ctrl[CTRL_EN];
  assign down    = ctrl[CTRL_DOWN];
  assign oneshot = ctrl[CTRL_ONESHOT];

  // Byte strobes above BITS simply fall off the end of the mask
  assign mask_full      = byte_mask(sel);
  assign bit_mask       = mask_full[BITS-1:0];
  assign wdata_b        = wdata[BITS-1:0];
  assign count_merged   = (count & ~bit_mask) | (wdata_b & bit_mask);
  assign compare_merged = (compare & ~bit_mask) | (wdata_b & bit_mask);

  // A bus write or LA load owns COUNT this cycle, so no terminal detection
  assign at_end   = down ? (count == '0) : (count == compare);
  assign terminal = en && !wr_count && !la_load && at_end;

  assign clear_match = wr_status && sel[0] && wdata[STATUS_MATCH];
  assign irq_req     = match && ctrl[CTRL_IRQEN];

  // Next count when stepping: reload on a periodic terminal, hold on a one-shot
  always_comb begin
    // NOTE: every always_comb output gets a default first so no path leaves it unassigned and infers a latch.
    step_val = down ? (count - 1'b1) : (count + 1'b1);
    if (terminal) begin
      if (oneshot) step_val = count;
      else         step_val = down ? compare : '0;
    end
  end

  // Channel state: bus write > LA load > count step on COUNT
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    if (reset) begin
      ctrl    <= '0;
      count   <= '0;
      compare <= '1;
      match   <= 1'b0;
    end else begin
      if (wr_count)     count <= count_merged;
      else if (la_load) count <= la_value;
      else if (en)      count <= step_val;

      if (wr_ctrl && sel[0])        ctrl          <= wdata[3:0];
      else if (terminal && oneshot) ctrl[CTRL_EN] <= 1'b0;

      if (wr_compare) compare <= compare_merged;

      // A terminal event in the same cycle as a W1C keeps the flag set
      if (terminal)         match <= 1'b1;
      else if (clear_match) match <= 1'b0;
    end
  end

  // Register read mux, zero-extended to the bus width
  always_comb begin
    rdata = '0;
    case (reg_sel)
      REG_CTRL:    rdata[3:0]      = ctrl;
      REG_COUNT:   rdata[BITS-1:0] = count;
      REG_COMPARE: rdata[BITS-1:0] = compare;
      REG_STATUS:  rdata[STATUS_MATCH] = match;
      default:     rdata = '0;
    endcase
  end

endmodule

// File: rtl/wb_counter_bank.sv
// Wishbone-controlled bank of NCH timer/counters with LA load override and a level irq.
module wb_counter_bank
  import wb_counter_bank_pkg::*;
#(
  parameter int NCH  = 4,
  parameter int BITS = 32
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              wbs_cyc_i,
  input  logic              wbs_stb_i,
  input  logic              wbs_we_i,
  input  logic [3:0]        wbs_sel_i,
  input  logic [31:0]       wbs_adr_i,
  input  logic [31:0]       wbs_dat_i,
  output logic              wbs_ack_o,
  output logic [31:0]       wbs_dat_o,
  input  logic [NCH-1:0]    la_load_i,
  input  logic [BITS-1:0]   la_value_i,
  output logic [NCH*BITS-1:0] count_o,
  output logic              irq_o
);

  localparam int CHW = (NCH > 1) ? $clog2(NCH) : 1;

  localparam logic [0:0] ST_IDLE = 1'b0;
  localparam logic [0:0] ST_ACK  = 1'b1;

  logic [0:0]     state;
  logic           valid;
  logic           accept;
  logic           in_range;
  logic           wr;
  logic [27:0]    chan_idx;
  logic [CHW-1:0] chan;
  logic [1:0]     reg_sel;
  logic [31:0]    rd_data;
  logic [31:0]    ch_rdata [NCH];
  logic [NCH-1:0] ch_irq;
  logic [NCH-1:0] ch_match;
  logic [1:0]     unused_adr;

  assign unused_adr = wbs_adr_i[1:0];

  assign valid  = wbs_cyc_i && wbs_stb_i;
  // A transfer is accepted only from IDLE, which forces a gap between acks
  assign accept = valid && (state == ST_IDLE);

  // The whole upper address decides range, so channel NCH never aliases channel 0
  assign chan_idx = wbs_adr_i[31:4];
  assign in_range = chan_idx < 28'(NCH);
  assign chan     = wbs_adr_i[4+CHW-1:4];
  assign reg_sel  = wbs_adr_i[3:2];
  assign wr       = accept && wbs_we_i && in_range;

  for (genvar n = 0; n < NCH; n++) begin : g_ch
    logic hit;
    assign hit = wr && (chan == CHW'(n));

    counter_channel #(.BITS(BITS)) u_ch (
      .clk        (clk),
      .reset      (reset),
      .wr_ctrl    (hit && (reg_sel == REG_CTRL)),
      .wr_count   (hit && (reg_sel == REG_COUNT)),
      .wr_compare (hit && (reg_sel == REG_COMPARE)),
      .wr_status  (hit && (reg_sel == REG_STATUS)),
      .sel        (wbs_sel_i),
      .wdata      (wbs_dat_i),
      .reg_sel    (reg_sel),
      .la_load    (la_load_i[n]),
      .la_value   (la_value_i),
      .count      (count_o[n*BITS +: BITS]),
      .rdata      (ch_rdata[n]),
      .match      (ch_match[n]),
      .irq_req    (ch_irq[n])
    );
  end

  // Read data for the addressed channel; out-of-range channels read zero
  always_comb begin
    rd_data = '0;
    if (in_range) rd_data = ch_rdata[chan];
  end

  // Ack FSM: one ack cycle per accepted transfer, then back to IDLE
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= ST_IDLE;
    end else begin
      case (state)
        ST_IDLE: if (valid) state <= ST_ACK;
        ST_ACK:  state <= ST_IDLE;
        default: state <= ST_IDLE;
      endcase
    end
  end

  assign wbs_ack_o = (state == ST_ACK);

  // Read data is captured as ack rises and held until the next read
  always_ff @(posedge clk) begin
    if (reset)                   wbs_dat_o <= '0;
    else if (accept && !wbs_we_i) wbs_dat_o <= rd_data;
  end

  // Registered level interrupt from any enabled sticky match
  always_ff @(posedge clk) begin
    if (reset) irq_o <= 1'b0;
    else       irq_o <= |ch_irq;
  end

endmodule

// File: tb/tb_wb_counter_bank.sv
// Self-checking bench: directed table, multi-cycle sequences, then random traffic vs a model.
module tb_wb_counter_bank;

  localparam int NCH  = 4;
  localparam int BITS = 32;

  logic              clk = 1'b0;
  logic              reset = 1'b1;
  logic              cyc = 1'b0, stb = 1'b0, we = 1'b0;
  logic [3:0]        sel = '0;
  logic [31:0]       adr = '0, wdat = '0;
  logic              ack;
  logic [31:0]       rdat;
  logic [NCH-1:0]    la_load = '0;
  logic [BITS-1:0]   la_value = '0;
  logic [NCH*BITS-1:0] count_o;
  logic              irq;

  logic              ack16;
  logic [31:0]       rdat16;
  logic [31:0]       count16;
  logic              irq16;

  int  n_checks = 0;
  int  n_fail   = 0;
  bit  rand_la  = 1'b0;
  bit  check_model = 1'b0;

  always #5 clk = ~clk;

  wb_counter_bank #(.NCH(NCH), .BITS(BITS)) dut (
    .clk(clk), .reset(reset),
    .wbs_cyc_i(cyc), .wbs_stb_i(stb), .wbs_we_i(we), .wbs_sel_i(sel),
    .wbs_adr_i(adr), .wbs_dat_i(wdat), .wbs_ack_o(ack), .wbs_dat_o(rdat),
    .la_load_i(la_load), .la_value_i(la_value), .count_o(count_o), .irq_o(irq)
  );

  // Narrow two-channel build sharing the same bus, for the BITS<32 read-back case
  wb_counter_bank #(.NCH(2), .BITS(16)) dut16 (
    .clk(clk), .reset(reset),
    .wbs_cyc_i(cyc), .wbs_stb_i(stb), .wbs_we_i(we), .wbs_sel_i(sel),
    .wbs_adr_i(adr), .wbs_dat_i(wdat), .wbs_ack_o(ack16), .wbs_dat_o(rdat16),
    .la_load_i(la_load[1:0]), .la_value_i(la_value[15:0]), .count_o(count16), .irq_o(irq16)
  );

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [BITS-1:0] ch_count(input int n);
    return count_o[n*BITS +: BITS];
  endfunction

  // ---------------- behavioural reference model ----------------
  logic [3:0]      m_ctrl  [NCH];
  logic [BITS-1:0] m_count [NCH];
  logic [BITS-1:0] m_cmp   [NCH];
  bit              m_match [NCH];
  bit              m_ack, m_irq;
  logic [31:0]     m_dat;

  function automatic logic [31:0] model_read(input int ch, input int r);
    case (r)
      0:       return {28'd0, m_ctrl[ch]};
      1:       return m_count[ch];
      2:       return m_cmp[ch];
      default: return {31'd0, m_match[ch]};
    endcase
  endfunction

  task automatic model_step();
    int ch, r;
    bit commit, nirq;
    logic [31:0] mask;
    if (reset) begin
      for (int n = 0; n < NCH; n++) begin
        m_ctrl[n] = 0; m_count[n] = 0; m_cmp[n] = '1; m_match[n] = 0;
      end
      m_ack = 0; m_irq = 0; m_dat = 0;
      return;
    end
    commit = cyc && stb && !m_ack;
    ch = int'(adr[31:4]);
    r  = int'(adr[3:2]);
    mask = 0;
    for (int b = 0; b < 4; b++) if (sel[b]) mask[8*b +: 8] = 8'hFF;
    nirq = 0;
    for (int n = 0; n < NCH; n++) if (m_match[n] && m_ctrl[n][3]) nirq = 1;
    if (commit && !we) m_dat = (ch < NCH) ? model_read(ch, r) : 32'd0;
    for (int n = 0; n < NCH; n++) begin
      bit hit, term;
      logic [3:0] c;
      hit  = commit && we && (ch == n);
      c    = m_ctrl[n];
      term = 0;
      if (hit && r == 1) m_count[n] = (m_count[n] & ~mask) | (wdat & mask);
      else if (la_load[n]) m_count[n] = la_value;
      else if (c[0]) begin
        if (c[1]) begin
          if (m_count[n] == 0) term = 1; else m_count[n] = m_count[n] - 1;
        end else begin
          if (m_count[n] == m_cmp[n]) term = 1; else m_count[n] = m_count[n] + 1;
        end
        if (term && !c[2]) m_count[n] = c[1] ? m_cmp[n] : '0;
      end
      if (hit && r == 2) m_cmp[n] = (m_cmp[n] & ~mask) | (wdat & mask);
      if (hit && r == 0 && sel[0]) m_ctrl[n] = wdat[3:0];
      else if (term && c[2])       m_ctrl[n][0] = 1'b0;
      if (term) m_match[n] = 1;
      else if (hit && r == 3 && sel[0] && wdat[0]) m_match[n] = 0;
    end
    m_ack = commit;
    m_irq = nirq;
  endtask

  always @(posedge clk) model_step();

  always @(negedge clk) begin
    if (check_model) begin
      for (int n = 0; n < NCH; n++) check($sformatf("model_count%0d", n), ch_count(n), m_count[n]);
      check("model_irq", irq, m_irq);
      check("model_ack", ack, m_ack);
      check("model_dat", rdat, m_dat);
    end
  end

  // ---------------- stimulus helpers ----------------
  task automatic tick();
    @(negedge clk);
    if (rand_la) begin
      for (int n = 0; n < NCH; n++) la_load[n] = ($urandom_range(0, 7) == 0);
      la_value = BITS'($urandom_range(0, 15));
    end
  endtask

  task automatic wb_xfer(input logic w, input logic [31:0] a, input logic [3:0] s,
                         input logic [31:0] d, output logic [31:0] rd, output logic [31:0] rd16);
    int n;
    cyc = 1; stb = 1; we = w; adr = a; sel = s; wdat = d;
    n = 0;
    do begin
      tick();
      n++;
    end while (!ack && n < 8);
    check("ack_latency", 64'(n), 64'd1);
    rd = rdat; rd16 = rdat16;
    cyc = 0; stb = 0; we = 0;
    tick();
    check("ack_drop", ack, 1'b0);
  endtask

  task automatic wb_write(input logic [31:0] a, input logic [31:0] d);
    logic [31:0] x, y;
    wb_xfer(1'b1, a, 4'hF, d, x, y);
  endtask

  task automatic wb_read_check(input string name, input logic [31:0] a, input logic [31:0] exp);
    logic [31:0] x, y;
    wb_xfer(1'b0, a, 4'hF, 32'd0, x, y);
    check(name, x, exp);
  endtask

  typedef struct {
    string       name;
    logic        w;
    logic [31:0] a;
    logic [3:0]  s;
    logic [31:0] d;
    logic [31:0] exp;
  } vec_t;

  vec_t tbl [16];

  initial begin
    logic [31:0] rd, rd16;
    bit found;

    tbl[0]  = '{"ch1_ctrl_rst",    1'b0, 32'h10, 4'hF, 32'h0,        32'h0};
    tbl[1]  = '{"ch1_count_rst",   1'b0, 32'h14, 4'hF, 32'h0,        32'h0};
    tbl[2]  = '{"ch1_compare_rst", 1'b0, 32'h18, 4'hF, 32'h0,        32'hFFFF_FFFF};
    tbl[3]  = '{"ch1_status_rst",  1'b0, 32'h1C, 4'hF, 32'h0,        32'h0};
    tbl[4]  = '{"wr_ch3_count_b2", 1'b1, 32'h34, 4'b0100, 32'hAABB_CCDD, 32'h0};
    tbl[5]  = '{"ch3_count_b2",    1'b0, 32'h34, 4'hF, 32'h0,        32'h00BB_0000};
    tbl[6]  = '{"wr_ch3_ctrl",     1'b1, 32'h30, 4'hF, 32'hFFFF_FFF0, 32'h0};
    tbl[7]  = '{"ch3_ctrl_upper0", 1'b0, 32'h30, 4'hF, 32'h0,        32'h0};
    tbl[8]  = '{"wr_ch3_cmp_lo",   1'b1, 32'h38, 4'b0011, 32'h1234_5678, 32'h0};
    tbl[9]  = '{"ch3_cmp_lo",      1'b0, 32'h38, 4'hF, 32'h0,        32'hFFFF_5678};
    tbl[10] = '{"wr_oor_count",    1'b1, 32'h44, 4'hF, 32'h0000_1234, 32'h0};
    tbl[11] = '{"oor_count_rd0",   1'b0, 32'h44, 4'hF, 32'h0,        32'h0};
    tbl[12] = '{"ch0_count_noalias", 1'b0, 32'h04, 4'hF, 32'h0,      32'h0};
    tbl[13] = '{"wr_oor_ctrl",     1'b1, 32'h40, 4'hF, 32'h0000_000F, 32'h0};
    tbl[14] = '{"ch0_ctrl_noalias", 1'b0, 32'h00, 4'hF, 32'h0,       32'h0};
    tbl[15] = '{"oor_ctrl_rd0",    1'b0, 32'h40, 4'hF, 32'h0,        32'h0};

    repeat (3) tick();
    reset = 0;
    tick();
    check("rst_ack", ack, 1'b0);
    check("rst_dat", rdat, 32'h0);
    check("rst_irq", irq, 1'b0);
    check("rst_count", count_o, '0);

    // Register map, byte strobes and out-of-range channel from the table
    for (int i = 0; i < 16; i++) begin
      wb_xfer(tbl[i].w, tbl[i].a, tbl[i].s, tbl[i].d, rd, rd16);
      if (!tbl[i].w) check(tbl[i].name, rd, tbl[i].exp);
    end

    // Channel 0: up, periodic, COMPARE=5
    wb_write(32'h08, 32'd5);
    wb_write(32'h00, 32'h1);
    for (int i = 0; i < 8; i++) begin
      check("ch0_up_seq", ch_count(0), BITS'((i + 1) % 6));
      tick();
    end
    check("ch0_irq_masked", irq, 1'b0);
    wb_read_check("ch0_match_set", 32'h0C, 32'h1);
    wb_write(32'h00, 32'h9);
    check("ch0_irq_on", irq, 1'b1);
    wb_write(32'h00, 32'h8);
    check("ch0_irq_held", irq, 1'b1);
    wb_write(32'h0C, 32'h1);
    check("ch0_irq_cleared", irq, 1'b0);
    wb_read_check("ch0_match_clr", 32'h0C, 32'h0);

    // Channel 2: down, one-shot from 3
    wb_write(32'h28, 32'd3);
    wb_write(32'h24, 32'd3);
    check("ch2_loaded", ch_count(2), BITS'(3));
    wb_write(32'h20, 32'h7);
    for (int i = 0; i < 5; i++) begin
      check("ch2_down_seq", ch_count(2), BITS'((i < 2) ? 2 - i : 0));
      tick();
    end
    wb_read_check("ch2_ctrl_en_clr", 32'h20, 32'h6);
    wb_read_check("ch2_match", 32'h2C, 32'h1);

    // Channel 1: LA load over a running counter, then bus write beats LA load
    wb_write(32'h14, 32'd8);
    wb_write(32'h10, 32'h1);
    check("ch1_running", ch_count(1), BITS'(9));
    la_load = 4'b0010; la_value = BITS'(32'h100);
    tick();
    check("ch1_la_load", ch_count(1), BITS'(32'h100));
    la_load = '0;
    tick();
    check("ch1_after_la", ch_count(1), BITS'(32'h101));
    cyc = 1; stb = 1; we = 1; adr = 32'h14; sel = 4'hF; wdat = 32'h55;
    la_load = 4'b0010;
    tick();
    check("wr_vs_la_ack", ack, 1'b1);
    check("wr_beats_la", ch_count(1), BITS'(32'h55));
    cyc = 0; stb = 0; we = 0; la_load = '0;
    tick();
    check("wr_beats_la_step", ch_count(1), BITS'(32'h56));

    // Channel 3: terminal event coincident with a W1C of STATUS
    wb_write(32'h30, 32'h0);
    wb_write(32'h34, 32'h0);
    wb_write(32'h38, 32'h10);
    wb_write(32'h30, 32'h1);
    found = 0;
    for (int i = 0; i < 40 && !found; i++) begin
      if (ch_count(3) == BITS'(32'h10)) found = 1;
      else tick();
    end
    check("ch3_reach_cmp", found, 1'b1);
    wb_xfer(1'b1, 32'h3C, 4'hF, 32'h1, rd, rd16);
    wb_read_check("term_beats_w1c", 32'h3C, 32'h1);

    // Narrow build drops bytes at or above BITS
    wb_xfer(1'b1, 32'h04, 4'hF, 32'hAABB_CCDD, rd, rd16);
    wb_xfer(1'b0, 32'h04, 4'hF, 32'h0, rd, rd16);
    check("bits32_full", rd, 32'hAABB_CCDD);
    check("bits16_zero_ext", rd16, 32'h0000_CCDD);

    // Random traffic against the reference model
    reset = 1;
    repeat (2) tick();
    reset = 0;
    rand_la = 1;
    check_model = 1;
    for (int t = 0; t < 200; t++) begin
      int chn, r, gap;
      logic [3:0] s;
      logic [31:0] d;
      gap = $urandom_range(0, 3);
      repeat (gap) tick();
      chn = $urandom_range(0, NCH);
      r   = $urandom_range(0, 3);
      s   = ($urandom_range(0, 1) == 1) ? 4'hF : 4'($urandom_range(0, 15));
      d   = ($urandom_range(0, 1) == 1) ? 32'($urandom_range(0, 12)) : $urandom();
      wb_xfer(1'($urandom_range(0, 1)), 32'((chn << 4) | (r << 2)), s, d, rd, rd16);
    end
    check_model = 0;
    rand_la = 0;

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/wb_counter_bank.md
Name: wb_counter_bank

Overview:
Bank of NCH independent BITS-wide timer/counters in the user area, controlled from the management SoC over Wishbone and overridable from Logic Analyzer probes.
Each channel counts up or down, runs periodic or one-shot against a programmable terminal value, and raises a sticky match flag that can drive an interrupt.
Counter values are exported for GPIO/LA observation.

Parameters:
NCH, 4, number of counter channels (1..8)
BITS, 32, counter width per channel (8..32)
CHW, $clog2(NCH) (min 1), channel-index width, derived, not overridden

Ports:
clk  in  1  clock
reset  in  1  synchronous, active-high reset
wbs_cyc_i  in  1  Wishbone cycle
wbs_stb_i  in  1  Wishbone strobe
wbs_we_i  in  1  write enable
wbs_sel_i  in  4  byte strobes
wbs_adr_i  in  32  byte address; [3:2] register select, [4+CHW-1:4] channel select
wbs_dat_i  in  32  write data
wbs_ack_o  out  1  single-cycle acknowledge
wbs_dat_o  out  32  read data
la_load_i  in  NCH  per-channel LA load request
la_value_i  in  BITS  LA load value, shared by all channels
count_o  out  NCH*BITS  packed counts; channel n at [n*BITS +: BITS]
irq_o  out  1  OR over all channels of (match & irq_en)

Behaviour:
- Clock and reset: clock clk; reset reset, synchronous, active-high. Reset clears all registers: CTRL=0, COUNT=0, COMPARE=all-ones, STATUS=0, wbs_ack_o=0, wbs_dat_o=0, irq_o=0.
- Register map per channel (word offsets):
  - 0 CTRL: bit0 en, bit1 down, bit2 oneshot, bit3 irq_en; other bits read 0.
  - 1 COUNT: read/write.
  - 2 COMPARE: read/write.
  - 3 STATUS: bit0 match; write 1 to clear.
- Wishbone handshake:
  - valid = cyc & stb.
  - Ack is asserted exactly one cycle after valid is seen with ack low; ack low the following cycle. Each transfer therefore takes ≥2 cycles; no back-to-back acks.
  - wbs_dat_o is registered in the same cycle ack rises and holds until the next read.
  - Writes apply per byte via wbs_sel_i. Bytes at or above BITS are ignored. Reads zero-extend to 32 bits.
  - A channel index ≥ NCH acks normally, reads 0, and ignores writes.
- Count step each cycle, when en=1:
  - up: if COUNT==COMPARE, terminal event; else COUNT+1.
  - down: if COUNT==0, terminal event; else COUNT-1.
- Terminal event:
  - match<=1 in all cases.
  - periodic (oneshot=0): up reloads 0, down reloads COMPARE.
  - oneshot=1: COUNT holds and en<=0.
- Arithmetic: modulo 2^BITS. An up count with COMPARE=all-ones wraps to 0 only through the terminal event.
- Precedence on COUNT, same cycle: Wishbone write to COUNT > la_load_i[n] (COUNT<=la_value_i, no terminal event) > count step.
  - A Wishbone write or LA load in a cycle suppresses stepping and terminal detection for that cycle.
  - LA load works regardless of en.
- Write to CTRL clearing en freezes COUNT from the next cycle. Setting en starts stepping the cycle after the write commits.
- STATUS: if a terminal event and a W1C land in the same cycle, the set wins (match stays 1).
- irq_o is registered, 1-cycle latency after match/irq_en change. It is level, held until every enabled match is cleared.
- count_o is a direct view of the COUNT registers.
- Reset mid-transaction drops ack. The master must reissue the transfer.

Decomposition:
- Package wb_counter_bank_pkg:
  - register offsets REG_CTRL=0, REG_COUNT=1, REG_COMPARE=2, REG_STATUS=3;
  - CTRL bit indices CTRL_EN, CTRL_DOWN, CTRL_ONESHOT, CTRL_IRQEN;
  - STATUS_MATCH.
- One sub-module, counter_channel:
  - holds CTRL, COUNT, COMPARE, match for one channel;
  - inputs: decoded write strobes/bytes, LA load;
  - outputs: count, read mux, match.
- Top: generate loop over NCH, Wishbone decode/ack FSM (IDLE/ACK), read mux, irq OR.

Test Plan:
- Reset, then read all registers of channel 1 → CTRL=0, COUNT=0, COMPARE=0xFFFFFFFF, STATUS=0; ack exactly 1 cycle after stb, low next cycle.
- Ch0 COMPARE=5, CTRL=0x1 (up, periodic) → count_o ch0 sequence 0,1,2,3,4,5,0,1…; match=1 after first wrap; with CTRL=0x9, irq_o=1 one cycle later; W1C STATUS → irq_o=0.
- Ch2 COMPARE=3, COUNT=3, CTRL=0x7 (down, oneshot) → 3,2,1,0 then holds 0; CTRL reads 0x6; match=1.
- Ch1 running up at 10, la_load_i[1]=1 with la_value_i=0x100 → COUNT=0x100 next cycle, then 0x101. Same cycle as a WB write of COUNT=0x55 → 0x55 wins.
- Write 0xAABBCCDD to COUNT with sel=4'b0100, en=0 → only byte 2 changes (0x00BB0000 from 0). With BITS=16 build, full write reads back 0x0000CCDD.
- Access to channel index NCH (e.g. adr 0x40 with NCH=4) → acked, reads 0, no channel state changes. Terminal event coincident with W1C → match remains 1.
